// File: rtl/zube_pkg.sv
// Shared types and constants for the zube I/O bridge Z80 front-end.
package zube_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SETTLE_W   = 3'd1,
        ST_SETTLE_R   = 3'd2,
        ST_WRITE_HOLD = 3'd3,
        ST_READ_WAIT  = 3'd4,
        ST_READ_DRIVE = 3'd5,
        ST_IGNORE     = 3'd6
    } state_t;

    localparam logic PORT_DATA      = 1'b0;
    localparam logic PORT_STATUS    = 1'b1;
    localparam logic SYNC_RESET_VAL = 1'b1;

    // Returns {hit, port}; base+1 wraps within 8 bits.
    function automatic logic [1:0] decode_window(input logic [7:0] addr, input logic [7:0] base);
        logic [7:0] base_next;
        base_next = base + 8'd1;
        if (addr == base)
            decode_window = {1'b1, PORT_DATA};
        else if (addr == base_next)
            decode_window = {1'b1, PORT_STATUS};
        else
            decode_window = 2'b00;
    endfunction

endpackage

// File: rtl/z80_strobe_sync.sv
// Multi-flop synchroniser for one active-low Z80 strobe; resets to the inactive level.
module z80_strobe_sync
    import zube_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe_async_b,
    output logic strobe_sync_b
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stages <= {SYNC_STAGES{SYNC_RESET_VAL}};
        else
            stages <= {stages[SYNC_STAGES-2:0], strobe_async_b};
    end

    assign strobe_sync_b = stages[SYNC_STAGES-1];

endmodule

// File: rtl/z80_io_frontend.sv
// Z80 bus front-end: strobe sync/settle, two-port window decode, write pulse and read handshake.
// Optional Z80_WAIT_EN adds z80_wait_b to stall the Z80 until read data is on the bus.
module z80_io_frontend
    import zube_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       z80_write_strobe_b,
    input  logic       z80_read_strobe_b,
    input  logic [7:0] z80_address_bus,
    input  logic [7:0] z80_data_bus_in,
    input  logic [7:0] base_address,
    output logic       wr_valid,
    output logic       wr_port,
    output logic [7:0] wr_data,
    output logic       rd_req,
    output logic       rd_port,
    input  logic       rd_ack,
    input  logic [7:0] rd_data,
    output logic [7:0] z80_data_bus_out,
    output logic       z80_bus_dir
`ifdef Z80_WAIT_EN
    ,
    output logic       z80_wait_b
`endif
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE_CYCLES);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             wr_s, rd_s;
    logic             settle_done, hit, port;
    logic             wr_valid_d, wr_port_d, rd_req_d, rd_port_d, bus_dir_d;
    logic [7:0]       wr_data_d, bus_out_d;

    z80_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
        .clk(clk), .reset(reset), .strobe_async_b(z80_write_strobe_b), .strobe_sync_b(wr_s)
    );

    z80_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
        .clk(clk), .reset(reset), .strobe_async_b(z80_read_strobe_b), .strobe_sync_b(rd_s)
    );

    assign settle_done = (cnt == SETTLE_CNT);
    assign {hit, port} = decode_window(z80_address_bus, base_address);

`ifdef Z80_WAIT_EN
    logic wait_q, wait_d;
    // Pull wait low already in the capture cycle of a read hit, ahead of the registered term.
    assign z80_wait_b = wait_q & ~((state == ST_SETTLE_R) & settle_done & hit);
`endif

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        wr_valid_d = 1'b0;
        wr_port_d  = wr_port;
        wr_data_d  = wr_data;
        rd_req_d   = 1'b0;
        rd_port_d  = rd_port;
        bus_out_d  = z80_data_bus_out;
        bus_dir_d  = z80_bus_dir;
`ifdef Z80_WAIT_EN
        wait_d     = wait_q;
`endif
        case (state)
            ST_IDLE: begin
                cnt_d = '0;
                if (!wr_s && rd_s) begin
                    state_d = ST_SETTLE_W;
                    cnt_d   = CNT_W'(1);
                end else if (!rd_s && wr_s) begin
                    state_d = ST_SETTLE_R;
                    cnt_d   = CNT_W'(1);
                end else if (!wr_s && !rd_s) begin
                    state_d = ST_IGNORE;
                end
            end
            ST_SETTLE_W: begin
                if (settle_done) begin
                    if (hit) begin
                        wr_valid_d = 1'b1;
                        wr_port_d  = port;
                        wr_data_d  = z80_data_bus_in;
                        state_d    = ST_WRITE_HOLD;
                    end else begin
                        state_d = ST_IGNORE;
                    end
                end else if (wr_s) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_SETTLE_R: begin
                if (settle_done) begin
                    if (hit) begin
                        rd_req_d  = 1'b1;
                        rd_port_d = port;
                        state_d   = ST_READ_WAIT;
`ifdef Z80_WAIT_EN
                        wait_d    = 1'b0;
`endif
                    end else begin
                        state_d = ST_IGNORE;
                    end
                end else if (rd_s) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_WRITE_HOLD: begin
                if (wr_s)
                    state_d = ST_IDLE;
            end
            ST_READ_WAIT: begin
                // A released strobe wins over a same-cycle ack: the Z80 cycle is already over.
                if (rd_s) begin
                    state_d = ST_IDLE;
`ifdef Z80_WAIT_EN
                    wait_d  = 1'b1;
`endif
                end else if (rd_ack) begin
                    bus_out_d = rd_data;
                    bus_dir_d = 1'b1;
                    state_d   = ST_READ_DRIVE;
`ifdef Z80_WAIT_EN
                    wait_d    = 1'b1;
`endif
                end
            end
            ST_READ_DRIVE: begin
                if (rd_s) begin
                    bus_dir_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_IGNORE: begin
                if (wr_s && rd_s)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            wr_valid         <= 1'b0;
            wr_port          <= 1'b0;
            wr_data          <= 8'h00;
            rd_req           <= 1'b0;
            rd_port          <= 1'b0;
            z80_data_bus_out <= 8'h00;
            z80_bus_dir      <= 1'b0;
        end else begin
            state            <= state_d;
            cnt              <= cnt_d;
            wr_valid         <= wr_valid_d;
            wr_port          <= wr_port_d;
            wr_data          <= wr_data_d;
            rd_req           <= rd_req_d;
            rd_port          <= rd_port_d;
            z80_data_bus_out <= bus_out_d;
            z80_bus_dir      <= bus_dir_d;
        end
    end

`ifdef Z80_WAIT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_q <= 1'b1;
        else
            wait_q <= wait_d;
    end
`endif

endmodule

// File: doc/z80_io_frontend.md
Name: z80_io_frontend

Overview:
Z80-side bus front-end for the zube I/O bridge. It sits between the Z80 pins and the register block.
- Synchronises the asynchronous Z80 strobes and glitch-filters them.
- Decodes the two-port I/O window at base_address and base_address+1.
- Emits one-cycle write transactions and a read request/acknowledge handshake.
- Drives the Z80 data bus and transceiver direction for the duration of a read.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the strobe synchroniser (minimum 2)
SETTLE_CYCLES, 2, consecutive synchronised-low cycles required before a strobe is accepted (minimum 1)

Ports:
clk  in  1  system (Wishbone) clock; the only clock
reset  in  1  asynchronous, active-high reset
z80_write_strobe_b  in  1  Z80 I/O write strobe, active low, asynchronous
z80_read_strobe_b  in  1  Z80 I/O read strobe, active low, asynchronous
z80_address_bus  in  8  Z80 A[7:0]
z80_data_bus_in  in  8  Z80 D[7:0] from the transceiver
base_address  in  8  I/O window base, quasi-static
wr_valid  out  1  one-cycle pulse: Z80 write accepted
wr_port  out  1  0 = data port, 1 = status port; valid while wr_valid
wr_data  out  8  captured write byte; valid while wr_valid
rd_req  out  1  one-cycle pulse: Z80 read of the window started
rd_port  out  1  0 = data, 1 = status; held from rd_req until return to IDLE
rd_ack  in  1  consumer supplies rd_data this cycle
rd_data  in  8  read byte, sampled when rd_ack is high
z80_data_bus_out  out  8  byte to drive onto the Z80 bus
z80_bus_dir  out  1  1 = transceiver drives the Z80 bus

Behaviour:
- Reset (asynchronous) forces the following, effective immediately without waiting for a clock edge:
  - all outputs to 0, including z80_bus_dir
  - state to IDLE, settle counter to 0
  - synchroniser flops to 1 (strobes inactive)
- Strobes pass through SYNC_STAGES flops; every FSM decision uses the synchronised versions only.
- Address and data are not synchronised. They are captured by a single register at the capture cycle, by which point they are stable.
- FSM states: IDLE, SETTLE_W, SETTLE_R, WRITE_HOLD, READ_WAIT, READ_DRIVE, IGNORE.
- IDLE:
  - write strobe low and read strobe high -> SETTLE_W, counter=1
  - read strobe low and write strobe high -> SETTLE_R, counter=1
  - both low -> IGNORE; no transaction
- SETTLE_W / SETTLE_R:
  - Counter increments each cycle the strobe stays low.
  - Strobe seen high before the counter reaches SETTLE_CYCLES -> IDLE, nothing emitted (glitch rejected).
  - On the cycle counter==SETTLE_CYCLES, capture the address and data and decode:
    - address==base_address -> port 0
    - address==base_address+1 (8-bit wrap; base 8'hFF gives port 1 at 8'h00) -> port 1
    - otherwise -> IGNORE
- Write hit: wr_valid=1 for exactly one cycle, with wr_port/wr_data, on the cycle after capture; state -> WRITE_HOLD.
- Write latency: the first clock edge sampling the pin low, plus SYNC_STAGES+SETTLE_CYCLES cycles, gives wr_valid high.
- WRITE_HOLD: wait for the synchronised strobe high -> IDLE. Exactly one wr_valid per strobe assertion.
- Read hit: rd_req=1 for one cycle on the cycle after capture; state -> READ_WAIT.
- READ_WAIT:
  - rd_ack (may arrive on the rd_req cycle or later) -> z80_data_bus_out<=rd_data and z80_bus_dir<=1 on the next edge; state -> READ_DRIVE.
  - Strobe high before rd_ack -> IDLE, bus never driven.
- rd_ack in any state other than READ_WAIT is ignored.
- READ_DRIVE: z80_data_bus_out is held stable. When the synchronised strobe goes high, z80_bus_dir<=0 on that edge; state -> IDLE.
- IGNORE: wait until both synchronised strobes are high -> IDLE.
- base_address changes take effect only at the next capture.
- z80_data_bus_out retains its last value after a read; only z80_bus_dir gates the drive.

Optional Feature:
Z80_WAIT_EN
- Defined:
  - Adds output port z80_wait_b (1 bit, reset value 1).
  - z80_wait_b=0 from the rd_req cycle until the cycle z80_bus_dir rises; also 0 in SETTLE_R for a read that hits.
  - The Z80 therefore stalls until data is on the bus.
  - Forced to 1 on abort and on reset.
- Undefined: no port; the consumer must ack within the Z80 read window or the read returns bus float.

Decomposition:
- Package zube_pkg holds:
  - the state enum (7 states, 3-bit encoding)
  - PORT_DATA=1'b0 and PORT_STATUS=1'b1
  - the reset value of the synchroniser, 1'b1
- Sub-module z80_strobe_sync: a parameterised SYNC_STAGES-deep 1-bit synchroniser with asynchronous reset to 1. It is instantiated twice, once per strobe.

Test Plan:
- Base 8'h80; write strobe low 10 cycles, A=8'h81, D=8'h5A -> one wr_valid pulse, wr_port=1, wr_data=8'h5A, 4 cycles after the first low sample.
- Write strobe low for 1 cycle only -> no wr_valid; state back to IDLE.
- Read A=8'h80, rd_ack 3 cycles after rd_req with rd_data=8'hC3 -> z80_bus_dir rises the cycle after ack with bus=8'hC3, and falls on the edge the synchronised strobe goes high.
- Read A=8'h80, strobe released before rd_ack; later rd_ack=1 -> z80_bus_dir never asserted.
- Base 8'hFF, write A=8'h00 -> wr_port=1; A=8'h7F -> no pulse (IGNORE); both strobes low together -> no pulse.
- Reset asserted mid READ_DRIVE -> z80_bus_dir=0 before the next clk edge, all outputs 0.
